// File: rtl/mesi_snoop_responder_pkg.sv
// Shared cache definitions: MESI line states, snoop op/response codes and address fields.
// The state and op rules used by the snoop responder live here.
package mesi_snoop_responder_pkg;

  localparam int D_LINES   = 8;
  localparam int D_TAG_LEN = 12;
  localparam int INDEX     = 14;
  localparam int B_OFFSET  = 6;

  localparam int ADDR_W    = 32;
  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = TAG_MSB - D_TAG_LEN + 1;
  localparam int INDEX_MSB = 19;
  localparam int INDEX_LSB = B_OFFSET;

  typedef enum logic [1:0] {
    M = 2'd0,
    E = 2'd1,
    S = 2'd2,
    I = 2'd3
  } states;

  typedef enum logic [1:0] {
    READ       = 2'd0,
    WRITE      = 2'd1,
    INVALIDATE = 2'd2,
    RWIM       = 2'd3
  } snoop_op_t;

  typedef enum logic [1:0] {
    HIT   = 2'd0,
    HITM  = 2'd1,
    NOHIT = 2'd2
  } snoop_rsp_t;

  // State a hit line moves to after another master's snoop.
  function automatic states snoop_next_state(snoop_op_t op, states cur);
    states nxt;
    nxt = cur;
    case (op)
      READ:             nxt = S;
      RWIM, INVALIDATE: nxt = I;
      default:          nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic snoop_illegal(snoop_op_t op, states cur);
    return (op == WRITE) || ((op == INVALIDATE) && ((cur == M) || (cur == E)));
  endfunction

endpackage

// File: rtl/mesi_snoop_responder_if.sv
// Snoop bus: request, writeback and response handshakes between a bus master and the responder.
interface mesi_snoop_responder_if;
  import mesi_snoop_responder_pkg::*;

  logic        snp_valid;
  logic        snp_ready;
  snoop_op_t   snp_op;
  logic [31:0] snp_addr;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_addr;

  logic        rsp_valid;
  logic        rsp_ready;
  snoop_rsp_t  rsp_result;

  modport master (
    output snp_valid, snp_op, snp_addr, wb_ready, rsp_ready,
    input  snp_ready, wb_valid, wb_addr, rsp_valid, rsp_result
  );

  modport slave (
    input  snp_valid, snp_op, snp_addr, wb_ready, rsp_ready,
    output snp_ready, wb_valid, wb_addr, rsp_valid, rsp_result
  );

endinterface

// File: rtl/mesi_snoop_responder_way_match.sv
// Combinational tag compare across the ways of one set; lowest matching valid way wins.
// Kept width-generic so a 4-way instruction-side lookup can reuse it.
module mesi_way_match
  import mesi_snoop_responder_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int TAG_W = 12
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] way_tags,
  input  logic [WAYS*2-1:0]     way_states,
  output logic                  hit,
  output logic [2:0]            way,
  output states                 hit_state
);

  // Scan from the top way down so the lowest hit is the last one to overwrite.
  always_comb begin
    hit       = 1'b0;
    way       = '0;
    hit_state = I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if ((states'(way_states[w*2 +: 2]) != I) &&
          (way_tags[w*TAG_W +: TAG_W] == tag)) begin
        hit       = 1'b1;
        way       = 3'(w);
        hit_state = states'(way_states[w*2 +: 2]);
      end
    end
  end

endmodule

// File: rtl/mesi_snoop_responder.sv
// Bus-side MESI snoop responder: looks up a snooped line, writes back modified data,
// downgrades/invalidates the line and returns HIT/HITM/NOHIT.
module mesi_snoop_responder
  import mesi_snoop_responder_pkg::*;
#(
  parameter int D_LINES   = mesi_snoop_responder_pkg::D_LINES,
  parameter int D_TAG_LEN = mesi_snoop_responder_pkg::D_TAG_LEN,
  parameter int INDEX     = mesi_snoop_responder_pkg::INDEX,
  parameter int B_OFFSET  = mesi_snoop_responder_pkg::B_OFFSET,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mesi_snoop_responder_if.slave        bus,
  output logic                         arr_rd_en,
  output logic [INDEX-1:0]             arr_rd_idx,
  input  logic [D_LINES*D_TAG_LEN-1:0] arr_rd_tags,
  input  logic [D_LINES*2-1:0]         arr_rd_states,
  output logic                         arr_wr_en,
  output logic [INDEX-1:0]             arr_wr_idx,
  output logic [2:0]                   arr_wr_way,
  output states                        arr_wr_state,
  output logic                         protocol_err,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             hitm_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CMP  = 3'd2,
    WB   = 3'd3,
    UPD  = 3'd4,
    RESP = 3'd5
  } fsm_t;

  fsm_t                 state_q, state_d;
  snoop_op_t            op_q;
  logic [D_TAG_LEN-1:0] tag_q;
  logic [INDEX-1:0]     idx_q;
  logic [2:0]           way_q;
  states                old_q;
  states                new_q;
  snoop_rsp_t           rsp_q;
  logic                 err_q;
  logic [CNT_W-1:0]     hit_cnt_q;
  logic [CNT_W-1:0]     hitm_cnt_q;

  logic                 m_hit;
  logic [2:0]           m_way;
  states                m_state;
  logic                 need_wb;
  logic                 unused_offset;

  assign unused_offset = ^bus.snp_addr[B_OFFSET-1:0];

  mesi_way_match #(
    .WAYS  (D_LINES),
    .TAG_W (D_TAG_LEN)
  ) u_way_match (
    .tag        (tag_q),
    .way_tags   (arr_rd_tags),
    .way_states (arr_rd_states),
    .hit        (m_hit),
    .way        (m_way),
    .hit_state  (m_state)
  );

  // Only a modified line that the other master will read or own needs its data flushed.
  assign need_wb = m_hit && (m_state == M) && ((op_q == READ) || (op_q == RWIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.snp_ready  = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.rsp_valid  = 1'b0;
    arr_rd_en      = 1'b0;
    arr_wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.snp_ready = 1'b1;
        if (bus.snp_valid) state_d = RD;
      end
      RD: begin
        arr_rd_en = 1'b1;
        state_d   = CMP;
      end
      CMP: begin
        state_d = need_wb ? WB : UPD;
      end
      WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) state_d = UPD;
      end
      UPD: begin
        arr_wr_en = (new_q != old_q);
        state_d   = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, lookup result and sticky error; a miss keeps old == new so nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= READ;
      tag_q <= '0;
      idx_q <= '0;
      way_q <= '0;
      old_q <= I;
      new_q <= I;
      rsp_q <= NOHIT;
      err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.snp_valid) begin
        op_q  <= bus.snp_op;
        tag_q <= bus.snp_addr[TAG_MSB -: D_TAG_LEN];
        idx_q <= bus.snp_addr[B_OFFSET +: INDEX];
      end
      if (state_q == CMP) begin
        way_q <= m_way;
        old_q <= m_state;
        new_q <= m_hit ? snoop_next_state(op_q, m_state) : m_state;
        if (!m_hit) begin
          rsp_q <= NOHIT;
        end else if (m_state == M) begin
          rsp_q <= HITM;
        end else begin
          rsp_q <= HIT;
        end
        if (m_hit && snoop_illegal(op_q, m_state)) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      hitm_cnt_q <= '0;
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      if ((rsp_q == HIT) && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if ((rsp_q == HITM) && (hitm_cnt_q != '1)) hitm_cnt_q <= hitm_cnt_q + 1'b1;
    end
  end

  assign arr_rd_idx     = idx_q;
  assign arr_wr_idx     = idx_q;
  assign arr_wr_way     = way_q;
  assign arr_wr_state   = new_q;
  assign bus.wb_addr    = {tag_q, idx_q, {B_OFFSET{1'b0}}};
  assign bus.rsp_result = rsp_q;
  assign protocol_err   = err_q;
  assign hit_cnt        = hit_cnt_q;
  assign hitm_cnt       = hitm_cnt_q;

endmodule
